// File: rtl/section_coeff_bank_pkg.sv
// Shared types and defaults for the section coefficient bank: coefficient
// widths, unity stdev reset value and the mean/stdev select encoding.
package section_coeff_bank_pkg;

    localparam int unsigned COEF_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 16;

    // Unity in Q16.16.
    localparam logic [COEF_W_DEF-1:0] STD_RESET = 32'h0001_0000;

    typedef enum logic {
        SEL_MEAN = 1'b0,
        SEL_STD  = 1'b1
    } coef_sel_e;

    typedef struct packed {
        logic [COEF_W_DEF-1:0] mean;
        logic [COEF_W_DEF-1:0] std;
    } coef_pair_t;

endpackage

// File: rtl/section_coeff_bank_if.sv
// Config, sample-in and tagged-sample-out signals of the section coefficient bank.
interface section_coeff_bank_if #(
    parameter int unsigned SEC_W  = 2,
    parameter int unsigned COEF_W = 32,
    parameter int unsigned DATA_W = 16
) ();

    logic              cfg_wr_en;
    logic [SEC_W-1:0]  cfg_wr_sec;
    logic              cfg_wr_sel;
    logic [COEF_W-1:0] cfg_wr_data;
    logic              cfg_commit;
    logic              cfg_commit_done;

    logic              in_valid;
    logic [SEC_W-1:0]  in_section;
    logic [DATA_W-1:0] in_data;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [COEF_W-1:0] out_mean;
    logic [COEF_W-1:0] out_std;
    logic              out_sec_err;
    logic [15:0]       err_count;

    modport master (
        output cfg_wr_en, cfg_wr_sec, cfg_wr_sel, cfg_wr_data, cfg_commit,
        output in_valid, in_section, in_data,
        input  cfg_commit_done,
        input  out_valid, out_data, out_mean, out_std, out_sec_err, err_count
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_sec, cfg_wr_sel, cfg_wr_data, cfg_commit,
        input  in_valid, in_section, in_data,
        output cfg_commit_done,
        output out_valid, out_data, out_mean, out_std, out_sec_err, err_count
    );

endinterface

// File: rtl/section_coeff_bank_dbuf.sv
// Double-buffered mean/stdev bank: shadow written by config, active copied
// from shadow on commit, combinational read of the active bank.
module coef_dbuf_bank
    import section_coeff_bank_pkg::*;
#(
    parameter int unsigned       NUM_SECTIONS = 4,
    parameter int unsigned       SEC_W        = 2,
    parameter int unsigned       COEF_W       = 32,
    parameter logic [COEF_W-1:0] STD_RESET    = COEF_W'(section_coeff_bank_pkg::STD_RESET)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [SEC_W-1:0]  wr_sec,
    input  logic              wr_sel,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              commit,
    input  logic [SEC_W-1:0]  rd_sec,
    output logic [COEF_W-1:0] rd_mean,
    output logic [COEF_W-1:0] rd_std
);

    logic [COEF_W-1:0] sh_mean  [NUM_SECTIONS];
    logic [COEF_W-1:0] sh_std   [NUM_SECTIONS];
    logic [COEF_W-1:0] act_mean [NUM_SECTIONS];
    logic [COEF_W-1:0] act_std  [NUM_SECTIONS];
    logic [COEF_W-1:0] nx_mean  [NUM_SECTIONS];
    logic [COEF_W-1:0] nx_std   [NUM_SECTIONS];

    // Next shadow contents; commit copies this so a same-cycle write is included.
    // Out-of-range write indices match no entry and are dropped.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SECTIONS; i++) begin
            nx_mean[i] = sh_mean[i];
            nx_std[i]  = sh_std[i];
            if (wr_en && wr_sec == i[SEC_W-1:0]) begin
                if (coef_sel_e'(wr_sel) == SEL_STD) begin
                    nx_std[i] = wr_data;
                end else begin
                    nx_mean[i] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SECTIONS; i++) begin
                sh_mean[i]  <= '0;
                sh_std[i]   <= STD_RESET;
                act_mean[i] <= '0;
                act_std[i]  <= STD_RESET;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SECTIONS; i++) begin
                sh_mean[i] <= nx_mean[i];
                sh_std[i]  <= nx_std[i];
                if (commit) begin
                    act_mean[i] <= nx_mean[i];
                    act_std[i]  <= nx_std[i];
                end
            end
        end
    end

    always_comb begin
        rd_mean = '0;
        rd_std  = '0;
        for (int unsigned i = 0; i < NUM_SECTIONS; i++) begin
            if (rd_sec == i[SEC_W-1:0]) begin
                rd_mean = act_mean[i];
                rd_std  = act_std[i];
            end
        end
    end

endmodule

// File: rtl/section_coeff_bank.sv
// Tags each ADC sample with the active mean/stdev of its section through a
// fixed two-stage pipeline; flags and counts out-of-range section indices.
module section_coeff_bank
    import section_coeff_bank_pkg::*;
#(
    parameter int unsigned       NUM_SECTIONS = 4,
    parameter int unsigned       SEC_W        = 2,
    parameter int unsigned       COEF_W       = COEF_W_DEF,
    parameter int unsigned       DATA_W       = DATA_W_DEF,
    parameter logic [COEF_W-1:0] STD_RESET    = COEF_W'(section_coeff_bank_pkg::STD_RESET)
) (
    input  logic                clk,
    input  logic                rst_n,
    section_coeff_bank_if.slave bus
);

    localparam logic [SEC_W:0] NUM_SEC = NUM_SECTIONS[SEC_W:0];

    logic              s1_valid;
    logic [SEC_W-1:0]  s1_sec;
    logic [DATA_W-1:0] s1_data;
    logic              s1_err;
    logic [COEF_W-1:0] rd_mean;
    logic [COEF_W-1:0] rd_std;

    logic              commit_done;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [COEF_W-1:0] out_mean;
    logic [COEF_W-1:0] out_std;
    logic              out_sec_err;
    logic [15:0]       err_count;

    coef_dbuf_bank #(
        .NUM_SECTIONS (NUM_SECTIONS),
        .SEC_W        (SEC_W),
        .COEF_W       (COEF_W),
        .STD_RESET    (STD_RESET)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.cfg_wr_en),
        .wr_sec  (bus.cfg_wr_sec),
        .wr_sel  (bus.cfg_wr_sel),
        .wr_data (bus.cfg_wr_data),
        .commit  (bus.cfg_commit),
        .rd_sec  (s1_sec),
        .rd_mean (rd_mean),
        .rd_std  (rd_std)
    );

    // The bank read returns zero for out-of-range indices.
    assign s1_err = ({1'b0, s1_sec} >= NUM_SEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_sec      <= '0;
            s1_data     <= '0;
            commit_done <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_mean    <= '0;
            out_std     <= '0;
            out_sec_err <= 1'b0;
            err_count   <= '0;
        end else begin
            s1_valid    <= bus.in_valid;
            s1_sec      <= bus.in_section;
            s1_data     <= bus.in_data;
            commit_done <= bus.cfg_commit;
            out_valid   <= s1_valid;
            out_sec_err <= s1_valid && s1_err;
            if (s1_valid) begin
                out_data <= s1_data;
                out_mean <= rd_mean;
                out_std  <= rd_std;
                if (s1_err && err_count != '1) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end

    assign bus.cfg_commit_done = commit_done;
    assign bus.out_valid       = out_valid;
    assign bus.out_data        = out_data;
    assign bus.out_mean        = out_mean;
    assign bus.out_std         = out_std;
    assign bus.out_sec_err     = out_sec_err;
    assign bus.err_count       = err_count;

endmodule
